// File: rtl/lsu_sbuf_if.sv
// Handshake bundle between the LSU and its neighbours (EXU op in, WBU result out,
// memory port, flush/fence sideband). The LSU uses the master view.
interface lsu_sbuf_if #(
    parameter int TAG_W = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_addr;
    logic [31:0]      in_wdata;
    logic [2:0]       in_funct3;
    logic             in_ren;
    logic             in_wen;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_misalign;
    logic [TAG_W-1:0] out_tag;

    logic             mem_req;
    logic             mem_gnt;
    logic             mem_wen;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wmask;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;

    logic             flush;
    logic             sb_empty;

    modport master (
        input  in_valid, in_addr, in_wdata, in_funct3, in_ren, in_wen, in_tag,
        output in_ready,
        output out_valid, out_result, out_misalign, out_tag,
        input  out_ready,
        output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  flush,
        output sb_empty
    );

    modport slave (
        output in_valid, in_addr, in_wdata, in_funct3, in_ren, in_wen, in_tag,
        input  in_ready,
        input  out_valid, out_result, out_misalign, out_tag,
        output out_ready,
        input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_gnt, mem_rvalid, mem_rdata,
        output flush,
        input  sb_empty
    );
endinterface

// File: rtl/lsu_sbuf.sv
// Load/store unit with a committed-store buffer draining in the background;
// loads bypass the buffer unless they hit a buffered store to the same word.
module lsu_sbuf #(
    parameter int SB_DEPTH = 4,
    parameter int TAG_W    = 64
) (
    input logic        clk,
    input logic        rst,
    lsu_sbuf_if.master bus
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(SB_DEPTH);

    typedef enum logic [2:0] {IDLE, LD_WAIT, LD_REQ, LD_RESP, DISCARD} state_e;

    state_e           state_q, state_d;
    logic [31:0]      ld_addr_q, ld_addr_d;
    logic [2:0]       ld_funct3_q, ld_funct3_d;
    logic [TAG_W-1:0] ld_tag_q, ld_tag_d;
    logic             ld_kill_q, ld_kill_d;

    logic             out_valid_q, out_valid_d;
    logic             out_misalign_q, out_misalign_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             mem_req_q, mem_req_d;
    logic             mem_wen_q, mem_wen_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wmask_q, mem_wmask_d;

    logic [29:0]         sb_addr_q [SB_DEPTH];
    logic [31:0]         sb_data_q [SB_DEPTH];
    logic [3:0]          sb_mask_q [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_vld_q, sb_vld_d;
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [PW:0]         count_q, count_d, sb_left;

    logic [1:0] off;
    logic       st_half, st_word, ld_half, ld_word, misalign, hazard;
    logic       in_ready, accept, push, pop, ld_gnt, ld_out;
    logic       port_free, issue_ld, issue_st;

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] o);
        case (f3)
            3'b000:  store_mask = 4'b0001 << o;
            3'b001:  store_mask = 4'b0011 << o;
            default: store_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] o,
                                                 input logic [2:0] f3);
        logic [31:0] sh;
        sh = w >> {o, 3'b000};
        case (f3)
            3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_extract = {24'b0, sh[7:0]};
            3'b101:  load_extract = {16'b0, sh[15:0]};
            default: load_extract = w;
        endcase
    endfunction

    always_comb begin
        off     = bus.in_addr[1:0];
        st_half = (bus.in_funct3 == 3'b001);
        st_word = (bus.in_funct3 != 3'b000) && !st_half;
        ld_half = (bus.in_funct3[1:0] == 2'b01);
        ld_word = (bus.in_funct3 == 3'b010);
        if (bus.in_wen)
            misalign = (st_half && off[0]) || (st_word && off != 2'b00);
        else if (bus.in_ren)
            misalign = (ld_half && off[0]) || (ld_word && off != 2'b00);
        else
            misalign = 1'b0;

        hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++)
            if (sb_vld_q[i] && sb_addr_q[i] == bus.in_addr[31:2]) hazard = 1'b1;

        // A pop in this cycle deliberately does not count as a free slot.
        in_ready = (state_q == IDLE) && !bus.flush && (!out_valid_q || bus.out_ready) &&
                   (!bus.in_wen || count_q < DEPTH_C);
        accept = bus.in_valid && in_ready;
        push   = accept && bus.in_wen && !misalign;
        ld_out = mem_req_q && !mem_wen_q;
        ld_gnt = ld_out && bus.mem_gnt;
        pop    = mem_req_q && mem_wen_q && bus.mem_gnt;
    end

    always_comb begin
        state_d     = state_q;
        ld_addr_d   = ld_addr_q;
        ld_funct3_d = ld_funct3_q;
        ld_tag_d    = ld_tag_q;
        ld_kill_d   = ld_kill_q;
        case (state_q)
            IDLE: begin
                if (accept && bus.in_ren && !bus.in_wen && !misalign) begin
                    ld_addr_d   = bus.in_addr;
                    ld_funct3_d = bus.in_funct3;
                    ld_tag_d    = bus.in_tag;
                    ld_kill_d   = 1'b0;
                    state_d     = hazard ? LD_WAIT : LD_REQ;
                end
            end
            LD_WAIT: begin
                if (bus.flush)            state_d = IDLE;
                else if (count_q == '0)   state_d = LD_REQ;
            end
            LD_REQ: begin
                // A request already on the port must complete, so a flush only marks it.
                if (ld_gnt)
                    state_d = (bus.flush || ld_kill_q) ? DISCARD : LD_RESP;
                else if (bus.flush) begin
                    if (ld_out) ld_kill_d = 1'b1;
                    else        state_d   = IDLE;
                end
            end
            LD_RESP: begin
                if (bus.mem_rvalid)   state_d = IDLE;
                else if (bus.flush)   state_d = DISCARD;
            end
            DISCARD: begin
                if (bus.mem_rvalid)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d   = head_q + PW'(pop);
        tail_d   = tail_q + PW'(push);
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
        sb_vld_d = sb_vld_q;
        if (pop)  sb_vld_d[head_q] = 1'b0;
        if (push) sb_vld_d[tail_q] = 1'b1;
        sb_left  = count_q - (PW+1)'(pop);

        // mem_req/mem_wen double as the port lock and its owner until mem_gnt.
        port_free = !mem_req_q || bus.mem_gnt;
        issue_ld  = port_free && (state_d == LD_REQ);
        issue_st  = port_free && !issue_ld && (sb_left != '0) &&
                    (state_d != LD_RESP) && (state_d != DISCARD);

        mem_req_d   = mem_req_q && !bus.mem_gnt;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        if (issue_ld) begin
            mem_req_d   = 1'b1;
            mem_wen_d   = 1'b0;
            mem_addr_d  = {ld_addr_d[31:2], 2'b00};
            mem_wdata_d = '0;
            mem_wmask_d = '0;
        end else if (issue_st) begin
            mem_req_d   = 1'b1;
            mem_wen_d   = 1'b1;
            mem_addr_d  = {sb_addr_q[head_d], 2'b00};
            mem_wdata_d = sb_data_q[head_d];
            mem_wmask_d = sb_mask_q[head_d];
        end
    end

    always_comb begin
        out_valid_d    = out_valid_q && !bus.out_ready;
        out_misalign_d = out_misalign_q;
        out_result_d   = out_result_q;
        out_tag_d      = out_tag_q;
        if (accept && (misalign || !bus.in_ren || bus.in_wen)) begin
            out_valid_d    = 1'b1;
            out_misalign_d = misalign;
            out_tag_d      = bus.in_tag;
            if (misalign || !bus.in_wen) out_result_d = bus.in_addr;
            else                         out_result_d = '0;
        end
        if (state_q == LD_RESP && bus.mem_rvalid && !bus.flush) begin
            out_valid_d    = 1'b1;
            out_misalign_d = 1'b0;
            out_result_d   = load_extract(bus.mem_rdata, ld_addr_q[1:0], ld_funct3_q);
            out_tag_d      = ld_tag_q;
        end
        if (bus.flush) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ld_kill_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            out_misalign_q <= 1'b0;
            out_result_q   <= '0;
            out_tag_q      <= '0;
            mem_req_q      <= 1'b0;
            mem_wen_q      <= 1'b0;
            sb_vld_q       <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            ld_kill_q      <= ld_kill_d;
            out_valid_q    <= out_valid_d;
            out_misalign_q <= out_misalign_d;
            out_result_q   <= out_result_d;
            out_tag_q      <= out_tag_d;
            mem_req_q      <= mem_req_d;
            mem_wen_q      <= mem_wen_d;
            sb_vld_q       <= sb_vld_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
        end
    end

    // Datapath registers carry no reset; their qualifiers above do.
    always_ff @(posedge clk) begin
        ld_addr_q   <= ld_addr_d;
        ld_funct3_q <= ld_funct3_d;
        ld_tag_q    <= ld_tag_d;
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= mem_wdata_d;
        mem_wmask_q <= mem_wmask_d;
        if (push) begin
            sb_addr_q[tail_q] <= bus.in_addr[31:2];
            sb_data_q[tail_q] <= bus.in_wdata << {off, 3'b000};
            sb_mask_q[tail_q] <= store_mask(bus.in_funct3, off);
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_result   = out_result_q;
    assign bus.out_misalign = out_misalign_q;
    assign bus.out_tag      = out_tag_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_wen      = mem_wen_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_wmask    = mem_wmask_q;
    assign bus.sb_empty     = (count_q == '0);
endmodule

// File: tb/tb_lsu_sbuf.sv
// Directed bench for lsu_sbuf: a vector table for single-op results plus
// hand-written sequences for buffer fill, hazard, arbitration and flush.
module tb_lsu_sbuf;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_sbuf_if #(.TAG_W(64)) ifc ();
    lsu_sbuf #(.SB_DEPTH(DEPTH), .TAG_W(64)) dut (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        logic [2:0]  f3;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] res;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] f3, input logic ren, input logic wen,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [63:0] tag);
        ifc.in_valid  = 1'b1;
        ifc.in_funct3 = f3;
        ifc.in_ren    = ren;
        ifc.in_wen    = wen;
        ifc.in_addr   = addr;
        ifc.in_wdata  = wdata;
        ifc.in_tag    = tag;
    endtask

    task automatic clr_op();
        ifc.in_valid = 1'b0;
        ifc.in_ren   = 1'b0;
        ifc.in_wen   = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (ifc.mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({name, " mem_req"}, ifc.mem_req, 1);
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (ifc.out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({name, " out_valid"}, ifc.out_valid, 1);
    endtask

    task automatic grant_store(input string name, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] mask);
        wait_req(name);
        check({name, " wen"},   ifc.mem_wen, 1);
        check({name, " addr"},  ifc.mem_addr, addr);
        check({name, " wdata"}, ifc.mem_wdata, data);
        check({name, " wmask"}, ifc.mem_wmask, mask);
        ifc.mem_gnt = 1'b1;
        step();
        ifc.mem_gnt = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        logic [63:0] tag;
        logic        is_ld;
        string       nm;
        v     = vecs[i];
        tag   = {32'hC0DE0000, 32'(i)};
        is_ld = v.ren && !v.wen && !v.mis;
        nm    = $sformatf("vec%0d", i);
        set_op(v.f3, v.ren, v.wen, v.addr, 32'h0, tag);
        #1 check({nm, " in_ready"}, ifc.in_ready, 1);
        step();
        clr_op();
        if (is_ld) begin
            wait_req(nm);
            check({nm, " ld wen"},  ifc.mem_wen, 0);
            check({nm, " ld addr"}, ifc.mem_addr, v.addr & 32'hFFFF_FFFC);
            ifc.mem_gnt = 1'b1;
            step();
            ifc.mem_gnt    = 1'b0;
            ifc.mem_rvalid = 1'b1;
            ifc.mem_rdata  = v.rdata;
            step();
            ifc.mem_rvalid = 1'b0;
        end else begin
            check({nm, " no mem_req"}, ifc.mem_req, 0);
            check({nm, " sb_empty"},   ifc.sb_empty, 1);
        end
        wait_out(nm);
        check({nm, " result"},   ifc.out_result, v.res);
        check({nm, " misalign"}, ifc.out_misalign, v.mis);
        check({nm, " tag"},      ifc.out_tag, tag);
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             f3      ren   wen   addr           rdata          mis   result
        vecs[0]  = '{3'b000, 1'b0, 1'b0, 32'h0000_1234, 32'h0,         1'b0, 32'h0000_1234};
        vecs[1]  = '{3'b001, 1'b1, 1'b0, 32'h0000_0101, 32'h0,         1'b1, 32'h0000_0101};
        vecs[2]  = '{3'b010, 1'b1, 1'b0, 32'h0000_0102, 32'h0,         1'b1, 32'h0000_0102};
        vecs[3]  = '{3'b010, 1'b0, 1'b1, 32'h0000_0203, 32'h0,         1'b1, 32'h0000_0203};
        vecs[4]  = '{3'b001, 1'b0, 1'b1, 32'h0000_0301, 32'h0,         1'b1, 32'h0000_0301};
        vecs[5]  = '{3'b100, 1'b1, 1'b0, 32'h8000_0003, 32'hAB00_0000, 1'b0, 32'h0000_00AB};
        vecs[6]  = '{3'b000, 1'b1, 1'b0, 32'h8000_0003, 32'h8000_0000, 1'b0, 32'hFFFF_FF80};
        vecs[7]  = '{3'b001, 1'b1, 1'b0, 32'h8000_0002, 32'h8001_1234, 1'b0, 32'hFFFF_8001};
        vecs[8]  = '{3'b101, 1'b1, 1'b0, 32'h8000_0002, 32'h8001_1234, 1'b0, 32'h0000_8001};
        vecs[9]  = '{3'b010, 1'b1, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vecs[10] = '{3'b000, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_007F, 1'b0, 32'h0000_007F};
        vecs[11] = '{3'b100, 1'b1, 1'b0, 32'h0000_0011, 32'h0000_FF00, 1'b0, 32'h0000_00FF};
        vecs[12] = '{3'b001, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_ABCD, 1'b0, 32'hFFFF_ABCD};
        vecs[13] = '{3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'hFFFF_FFFF};

        rst = 1'b1;
        clr_op();
        ifc.in_addr = '0; ifc.in_wdata = '0; ifc.in_funct3 = '0; ifc.in_tag = '0;
        ifc.out_ready = 1'b1;
        ifc.mem_gnt = 1'b0; ifc.mem_rvalid = 1'b0; ifc.mem_rdata = '0;
        ifc.flush = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("rst out_valid",    ifc.out_valid, 0);
        check("rst out_misalign", ifc.out_misalign, 0);
        check("rst out_result",   ifc.out_result, 0);
        check("rst out_tag",      ifc.out_tag, 0);
        check("rst mem_req",      ifc.mem_req, 0);
        check("rst mem_wen",      ifc.mem_wen, 0);
        check("rst sb_empty",     ifc.sb_empty, 1);
        check("rst in_ready",     ifc.in_ready, 1);
        step();

        for (int i = 0; i < NV; i++) run_vec(i);

        // Output hold while WBU back-pressures.
        set_op(3'b000, 1'b0, 1'b0, 32'h55, 32'h0, 64'h11);
        step();
        clr_op();
        ifc.out_ready = 1'b0;
        check("hold valid0", ifc.out_valid, 1);
        step();
        set_op(3'b000, 1'b0, 1'b0, 32'h66, 32'h0, 64'h22);
        #1 check("hold in_ready", ifc.in_ready, 0);
        step();
        check("hold valid1",  ifc.out_valid, 1);
        check("hold result",  ifc.out_result, 32'h55);
        ifc.out_ready = 1'b1;
        #1 check("hold release rdy", ifc.in_ready, 1);
        step();
        clr_op();
        check("hold next result", ifc.out_result, 32'h66);
        check("hold next tag",    ifc.out_tag, 64'h22);
        step();
        check("hold drained", ifc.out_valid, 0);

        // SB then LBU to the same word: load waits for the drain.
        set_op(3'b000, 1'b0, 1'b1, 32'h8000_0003, 32'h0000_00AB, 64'hAAA);
        #1 check("haz st rdy", ifc.in_ready, 1);
        step();
        check("haz st valid",  ifc.out_valid, 1);
        check("haz st result", ifc.out_result, 0);
        check("haz sb_empty0", ifc.sb_empty, 0);
        set_op(3'b100, 1'b1, 1'b0, 32'h8000_0003, 32'h0, 64'hBBB);
        #1 check("haz ld rdy", ifc.in_ready, 1);
        step();
        clr_op();
        check("haz out consumed", ifc.out_valid, 0);
        grant_store("haz st", 32'h8000_0000, 32'hAB00_0000, 4'b1000);
        check("haz sb_empty1", ifc.sb_empty, 1);
        wait_req("haz ld");
        check("haz ld wen",  ifc.mem_wen, 0);
        check("haz ld addr", ifc.mem_addr, 32'h8000_0000);
        ifc.mem_gnt = 1'b1;
        step();
        ifc.mem_gnt = 1'b0; ifc.mem_rvalid = 1'b1; ifc.mem_rdata = 32'hAB00_0000;
        step();
        ifc.mem_rvalid = 1'b0;
        wait_out("haz ld");
        check("haz ld result", ifc.out_result, 32'h0000_00AB);
        check("haz ld tag",    ifc.out_tag, 64'hBBB);
        step();

        // Fill the buffer with memory stalled, then one more store.
        for (int i = 0; i <= DEPTH; i++) begin
            set_op(3'b010, 1'b0, 1'b1, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 64'(i));
            #1 check($sformatf("fill%0d rdy", i), ifc.in_ready, (i < DEPTH));
            if (i < DEPTH) begin
                step();
                check($sformatf("fill%0d valid", i),  ifc.out_valid, 1);
                check($sformatf("fill%0d result", i), ifc.out_result, 0);
            end
        end
        check("fill head addr",  ifc.mem_addr, 32'h1000);
        check("fill head wdata", ifc.mem_wdata, 32'hA0);
        ifc.mem_gnt = 1'b1;
        #1 check("fill pop same cycle rdy", ifc.in_ready, 0);
        step();
        ifc.mem_gnt = 1'b0;
        #1 check("fill after pop rdy", ifc.in_ready, 1);
        step();
        clr_op();
        check("fill last valid",  ifc.out_valid, 1);
        check("fill last result", ifc.out_result, 0);
        for (int k = 1; k <= DEPTH; k++)
            grant_store($sformatf("drain%0d", k), 32'h1000 + 32'(4 * k), 32'hA0 + 32'(k), 4'b1111);
        check("fill sb_empty", ifc.sb_empty, 1);

        // Load to a different word bypasses a buffered store.
        set_op(3'b010, 1'b0, 1'b1, 32'h200, 32'h55, 64'h1);
        step();
        set_op(3'b010, 1'b1, 1'b0, 32'h100, 32'h0, 64'h2);
        #1 check("byp ld rdy", ifc.in_ready, 1);
        step();
        clr_op();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("byp req c%0d", c),  ifc.mem_req, 1);
            check($sformatf("byp wen c%0d", c),  ifc.mem_wen, 0);
            check($sformatf("byp addr c%0d", c), ifc.mem_addr, 32'h100);
            step();
        end
        ifc.mem_gnt = 1'b1;
        step();
        ifc.mem_gnt = 1'b0;
        check("byp no store in resp", ifc.mem_req, 0);
        ifc.mem_rvalid = 1'b1; ifc.mem_rdata = 32'h1122_3344;
        step();
        ifc.mem_rvalid = 1'b0;
        wait_out("byp ld");
        check("byp ld result", ifc.out_result, 32'h1122_3344);
        grant_store("byp st", 32'h200, 32'h55, 4'b1111);

        // Flush a granted load; buffered store survives.
        set_op(3'b010, 1'b0, 1'b1, 32'h400, 32'h77, 64'h3);
        step();
        set_op(3'b010, 1'b1, 1'b0, 32'h300, 32'h0, 64'h4);
        step();
        clr_op();
        check("fl ld wen",  ifc.mem_wen, 0);
        check("fl ld addr", ifc.mem_addr, 32'h300);
        ifc.mem_gnt = 1'b1;
        step();
        ifc.mem_gnt = 1'b0;
        ifc.flush = 1'b1;
        #1 check("fl flush rdy", ifc.in_ready, 0);
        step();
        ifc.flush = 1'b0;
        set_op(3'b000, 1'b0, 1'b0, 32'h999, 32'h0, 64'h5);
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("fl rdy c%0d", c),   ifc.in_ready, 0);
            check($sformatf("fl valid c%0d", c), ifc.out_valid, 0);
            check($sformatf("fl req c%0d", c),   ifc.mem_req, 0);
            step();
        end
        ifc.mem_rvalid = 1'b1; ifc.mem_rdata = 32'hBAD0_BAD0;
        clr_op();
        step();
        ifc.mem_rvalid = 1'b0;
        check("fl idle rdy",  ifc.in_ready, 1);
        check("fl no result", ifc.out_valid, 0);
        check("fl sb kept",   ifc.sb_empty, 0);
        grant_store("fl st", 32'h400, 32'h77, 4'b1111);
        check("fl sb_empty", ifc.sb_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
